// File: rtl/hsid_mse_sched.sv
// hsid_mse_sched: sequencer for the hsid_mse datapath.
// After a start pulse it streams one pixel vector against the first N library
// vectors, gathers the MSE results and reports the minimum and its reference.
//
// Ports:
//   clk, rst_n                    clock (rising edge), async active-low reset
//   start, library_size           command pulse and vector count (sampled in IDLE)
//   pixel_addr/pixel_data         pixel buffer read port (1-cycle read latency)
//   lib_addr/lib_data             library read port (1-cycle read latency)
//   mem_rd_en                     read enable shared by both memories
//   element_*                     element pair stream towards hsid_mse
//   vctr_ref                      library index of the current element pair
//   mse_value/mse_ref/mse_valid   results returned by hsid_mse
//   busy, done                    operation status, one-cycle completion pulse
//   min_mse_value/min_mse_ref     best result of the last run
//   ref_error                     sticky out-of-order result flag
module hsid_mse_sched #(
  parameter  int WORD_WIDTH       = 32,
  parameter  int DATA_WIDTH       = 16,
  parameter  int HSI_BANDS        = 128,
  parameter  int HSI_LIBRARY_SIZE = 32,
  localparam int DATA_PER_WORD    = WORD_WIDTH / DATA_WIDTH,
  localparam int ELEMENTS         = HSI_BANDS / DATA_PER_WORD,
  localparam int LIB_ADDR         = $clog2(HSI_LIBRARY_SIZE),
  localparam int EL_W             = $clog2(ELEMENTS),
  localparam int LA_W             = LIB_ADDR + EL_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LIB_ADDR:0]     library_size,
  output logic [EL_W-1:0]       pixel_addr,
  input  logic [WORD_WIDTH-1:0] pixel_data,
  output logic [LA_W-1:0]       lib_addr,
  input  logic [WORD_WIDTH-1:0] lib_data,
  output logic                  mem_rd_en,
  output logic                  element_start,
  output logic                  element_last,
  output logic [WORD_WIDTH-1:0] element_a,
  output logic [WORD_WIDTH-1:0] element_b,
  output logic                  element_valid,
  output logic [LIB_ADDR-1:0]   vctr_ref,
  input  logic [WORD_WIDTH-1:0] mse_value,
  input  logic [LIB_ADDR-1:0]   mse_ref,
  input  logic                  mse_valid,
  output logic                  busy,
  output logic                  done,
  output logic [WORD_WIDTH-1:0] min_mse_value,
  output logic [LIB_ADDR-1:0]   min_mse_ref,
  output logic                  ref_error
);

  localparam logic [LIB_ADDR:0] N_MAX  = (LIB_ADDR+1)'(HSI_LIBRARY_SIZE);
  localparam logic [EL_W-1:0]   J_LAST = EL_W'(ELEMENTS - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t                r_state;
  logic [LIB_ADDR:0]     r_n;
  logic [LIB_ADDR:0]     r_cnt;
  logic [EL_W-1:0]       r_j;
  logic [LIB_ADDR-1:0]   r_ref;
  logic                  r_rd_en;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_ref_err;
  logic [WORD_WIDTH-1:0] r_min;
  logic [LIB_ADDR-1:0]   r_min_ref;

  // Framing stage aligned with the memory access cycle.
  logic                  r_s1_valid;
  logic                  r_s1_start;
  logic                  r_s1_last;
  logic [LIB_ADDR-1:0]   r_s1_ref;

  // Output stage, aligned with the returned memory data.
  logic                  r_el_valid;
  logic                  r_el_start;
  logic                  r_el_last;
  logic [WORD_WIDTH-1:0] r_el_a;
  logic [WORD_WIDTH-1:0] r_el_b;
  logic [LIB_ADDR-1:0]   r_el_ref;

  logic [LIB_ADDR:0]     w_n_sat;
  logic                  w_last_j;
  logic                  w_last_ref;
  logic                  w_collect;
  logic [LA_W-1:0]       w_lib_addr;

  assign w_n_sat    = (library_size > N_MAX) ? N_MAX : library_size;
  assign w_last_j   = (r_j == J_LAST);
  assign w_last_ref = ({1'b0, r_ref} == (r_n - 1'b1));
  assign w_collect  = mse_valid && ((r_state == S_STREAM) || (r_state == S_DRAIN));
  assign w_lib_addr = LA_W'(r_ref) * LA_W'(ELEMENTS) + LA_W'(r_j);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_n       <= '0;
      r_cnt     <= '0;
      r_j       <= '0;
      r_ref     <= '0;
      r_rd_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ref_err <= 1'b0;
      r_min     <= '1;
      r_min_ref <= '0;
    end else begin
      r_done <= 1'b0;
      // Never active in IDLE, so it cannot collide with the start-time clears.
      if (w_collect) begin
        r_cnt <= r_cnt + 1'b1;
        if ({1'b0, mse_ref} != r_cnt) r_ref_err <= 1'b1;
        // Strict compare: a tie keeps the earlier reference.
        if (mse_value < r_min) begin
          r_min     <= mse_value;
          r_min_ref <= mse_ref;
        end
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_n       <= w_n_sat;
            r_cnt     <= '0;
            r_min     <= '1;
            r_min_ref <= '0;
            r_ref_err <= 1'b0;
            r_busy    <= 1'b1;
            r_j       <= '0;
            r_ref     <= '0;
            if (w_n_sat == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_STREAM;
              r_rd_en <= 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (w_last_j && w_last_ref) begin
            r_rd_en <= 1'b0;
            r_state <= S_DRAIN;
          end else if (w_last_j) begin
            r_j   <= '0;
            r_ref <= r_ref + 1'b1;
          end else begin
            r_j <= r_j + 1'b1;
          end
        end
        S_DRAIN: begin
          if (r_cnt == r_n) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_start <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_ref   <= '0;
      r_el_valid <= 1'b0;
      r_el_start <= 1'b0;
      r_el_last  <= 1'b0;
      r_el_a     <= '0;
      r_el_b     <= '0;
      r_el_ref   <= '0;
    end else begin
      r_s1_valid <= r_rd_en;
      r_s1_start <= r_rd_en && (r_j == '0);
      r_s1_last  <= r_rd_en && w_last_j;
      r_s1_ref   <= r_ref;
      r_el_valid <= r_s1_valid;
      r_el_start <= r_s1_start;
      r_el_last  <= r_s1_last;
      if (r_s1_valid) begin
        r_el_a   <= pixel_data;
        r_el_b   <= lib_data;
        r_el_ref <= r_s1_ref;
      end
    end
  end

  assign pixel_addr    = r_j;
  assign lib_addr      = w_lib_addr;
  assign mem_rd_en     = r_rd_en;
  assign element_valid = r_el_valid;
  assign element_start = r_el_start;
  assign element_last  = r_el_last;
  assign element_a     = r_el_a;
  assign element_b     = r_el_b;
  assign vctr_ref      = r_el_ref;
  assign busy          = r_busy;
  assign done          = r_done;
  assign min_mse_value = r_min;
  assign min_mse_ref   = r_min_ref;
  assign ref_error     = r_ref_err;

endmodule

// File: tb/tb_hsid_mse_sched.sv
// Self-checking bench for hsid_mse_sched: random memory contents and results,
// expected stream and minimum derived directly from the behavioural rules.
module tb_hsid_mse_sched;

  localparam int WW = 32;
  localparam int LA = 5;
  localparam int EW = 6;
  localparam int EL = 64;
  localparam int LS = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [LA:0]   library_size;
  logic [EW-1:0] pixel_addr;
  logic [WW-1:0] pixel_data;
  logic [LA+EW-1:0] lib_addr;
  logic [WW-1:0] lib_data;
  logic          mem_rd_en;
  logic          element_start;
  logic          element_last;
  logic [WW-1:0] element_a;
  logic [WW-1:0] element_b;
  logic          element_valid;
  logic [LA-1:0] vctr_ref;
  logic [WW-1:0] mse_value;
  logic [LA-1:0] mse_ref;
  logic          mse_valid;
  logic          busy;
  logic          done;
  logic [WW-1:0] min_mse_value;
  logic [LA-1:0] min_mse_ref;
  logic          ref_error;

  hsid_mse_sched #(
    .WORD_WIDTH(32), .DATA_WIDTH(16), .HSI_BANDS(128), .HSI_LIBRARY_SIZE(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .library_size(library_size),
    .pixel_addr(pixel_addr), .pixel_data(pixel_data),
    .lib_addr(lib_addr), .lib_data(lib_data), .mem_rd_en(mem_rd_en),
    .element_start(element_start), .element_last(element_last),
    .element_a(element_a), .element_b(element_b), .element_valid(element_valid),
    .vctr_ref(vctr_ref), .mse_value(mse_value), .mse_ref(mse_ref),
    .mse_valid(mse_valid), .busy(busy), .done(done),
    .min_mse_value(min_mse_value), .min_mse_ref(min_mse_ref), .ref_error(ref_error)
  );

  always #5 clk = ~clk;

  logic [WW-1:0] pix_mem [EL];
  logic [WW-1:0] lib_mem [LS*EL];

  // Synchronous-read memories.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      pixel_data <= pix_mem[pixel_addr];
      lib_data   <= lib_mem[lib_addr];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  int unsigned res_val [LS];
  int unsigned res_ref [LS];

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full operation: start, follow the stream, feed results, check outcome.
  task automatic run_op(input int unsigned n_req, input bit busy_start);
    int unsigned n_eff, e_idx, first_t, last_t, done_cnt, done_t, feed, t;
    bit seen, fin, exp_err;
    logic [WW-1:0] exp_min;
    int unsigned exp_ref;
    n_eff = (n_req > LS) ? LS : n_req;
    e_idx = 0; first_t = 0; last_t = 0; done_cnt = 0; done_t = 0; feed = 0;
    seen = 0; fin = 0; exp_err = 0; exp_min = '1; exp_ref = 0;
    for (int unsigned k = 0; k < n_eff; k++) begin
      if (res_ref[k] != k) exp_err = 1;
      if (res_val[k] < exp_min) begin
        exp_min = res_val[k];
        exp_ref = res_ref[k];
      end
    end
    @(negedge clk);
    start = 1'b1;
    library_size = n_req[LA:0];
    @(negedge clk);
    start = 1'b0;
    t = 1;
    while (!fin) begin
      if (t == 1) check("busy_rise", busy, 1);
      if (element_valid) begin
        int unsigned r, j;
        r = e_idx / EL;
        j = e_idx % EL;
        if (!seen) first_t = t;
        seen = 1;
        last_t = t;
        if (e_idx < n_eff*EL)
          check("element", {element_a, element_b, element_start, element_last, vctr_ref},
                {pix_mem[j], lib_mem[r*EL+j], (j == 0), (j == EL-1), r[LA-1:0]});
        e_idx++;
      end
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_t = t;
          check("done_min", min_mse_value, exp_min);
          check("done_ref", min_mse_ref, exp_ref);
          check("done_referr", ref_error, exp_err);
          check("done_busy", busy, 1);
        end
      end
      if (done_cnt > 0 && t >= done_t + 2) fin = 1;
      if (!fin && t > n_eff*EL + 300) begin
        check("timeout_done", done_cnt, 1);
        fin = 1;
      end
      start = busy_start && (t == 40);
      if (busy_start) library_size = 6'd5;
      mse_valid = 1'b0;
      if (seen && !element_valid && e_idx >= n_eff*EL && feed < n_eff &&
          $urandom_range(0, 2) != 0) begin
        mse_valid = 1'b1;
        mse_value = res_val[feed];
        mse_ref   = LA'(res_ref[feed]);
        feed++;
      end
      @(negedge clk);
      t++;
    end
    start = 1'b0;
    mse_valid = 1'b0;
    check("stream_len", e_idx, n_eff*EL);
    if (n_eff > 0) begin
      check("first_valid_t", first_t, 3);
      check("contiguous", last_t - first_t + 1, n_eff*EL);
    end else begin
      check("done_latency", done_t, 1);
    end
    check("done_count", done_cnt, 1);
    check("idle_busy", busy, 0);
    check("hold_min", min_mse_value, exp_min);
    check("hold_referr", ref_error, exp_err);
  endtask

  task automatic set_inorder(input int unsigned n, input int unsigned vmax);
    for (int unsigned k = 0; k < LS; k++) begin
      res_val[k] = $urandom_range(0, vmax);
      res_ref[k] = k;
    end
  endtask

  task automatic reset_mid_stream();
    int unsigned cnt, t;
    cnt = 0;
    t = 0;
    @(negedge clk);
    start = 1'b1;
    library_size = 6'd2;
    @(negedge clk);
    start = 1'b0;
    while (cnt < 30 && t < 200) begin
      if (element_valid) cnt++;
      if (cnt < 30) begin
        @(negedge clk);
        t++;
      end
    end
    check("rst_reach", cnt, 30);
    rst_n = 1'b0;
    #1;
    check("rst_ctl", {busy, done, element_valid, mem_rd_en, element_start, element_last, ref_error}, 0);
    check("rst_min", min_mse_value, 32'hFFFF_FFFF);
    check("rst_addr", {pixel_addr, lib_addr, vctr_ref, min_mse_ref}, 0);
    check("rst_elem", {element_a, element_b}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    library_size = '0;
    mse_valid = 1'b0;
    mse_value = '0;
    mse_ref = '0;
    for (int i = 0; i < EL; i++) pix_mem[i] = $urandom;
    for (int i = 0; i < LS*EL; i++) lib_mem[i] = $urandom;
    repeat (3) @(negedge clk);
    check("reset_ctl", {busy, done, element_valid, mem_rd_en, ref_error}, 0);
    check("reset_min", min_mse_value, 32'hFFFF_FFFF);
    check("reset_ref", min_mse_ref, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic run.
    res_val[0] = 40; res_val[1] = 10; res_val[2] = 25;
    res_ref[0] = 0;  res_ref[1] = 1;  res_ref[2] = 2;
    run_op(3, 0);
    check("basic_min", min_mse_value, 10);
    check("basic_ref", min_mse_ref, 1);

    // Tie keeps the lower reference.
    res_val[0] = 7; res_val[1] = 7; res_ref[0] = 0; res_ref[1] = 1;
    run_op(2, 0);
    check("tie_ref", min_mse_ref, 0);

    // Empty library.
    run_op(0, 0);
    check("n0_min", min_mse_value, 32'hFFFF_FFFF);

    // Results in IDLE are ignored.
    mse_valid = 1'b1; mse_value = 32'd3; mse_ref = 5'd4;
    @(negedge clk);
    mse_valid = 1'b0;
    @(negedge clk);
    check("idle_mse_min", min_mse_value, 32'hFFFF_FFFF);
    check("idle_mse_err", ref_error, 0);

    // Out-of-order results.
    set_inorder(2, 1000);
    res_ref[0] = 1; res_ref[1] = 0;
    run_op(2, 0);

    // Start while busy.
    set_inorder(2, 1000);
    run_op(2, 1);

    // Reset mid-stream, then a fresh single-vector run.
    reset_mid_stream();
    set_inorder(1, 1000);
    run_op(1, 0);

    // Random runs with small values so ties occur.
    for (int it = 0; it < 5; it++) begin
      int unsigned n, a, b, tmp;
      n = $urandom_range(1, 8);
      set_inorder(n, 20);
      if ($urandom_range(0, 3) == 0) begin
        a = $urandom_range(0, n-1);
        b = $urandom_range(0, n-1);
        tmp = res_ref[a]; res_ref[a] = res_ref[b]; res_ref[b] = tmp;
      end
      run_op(n, 0);
    end

    // Oversized request saturates to the full library.
    set_inorder(LS, 32'hFFFF_FFF0);
    run_op(40, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hsid_mse_sched.md
Name: hsid_mse_sched

Overview:
- Sequencer for the hsid_mse datapath in the spectral-identification core.
- After a start command, compares one captured pixel vector against the first N library vectors:
  - reads pixel and library words from synchronous-read memories;
  - streams element pairs into hsid_mse back-to-back, with start/last framing and a reference index per vector;
  - collects every MSE result and reports the minimum MSE and its reference index.

Parameters:
- WORD_WIDTH, 32: memory/element word width.
- DATA_WIDTH, 16: sample width; DATA_PER_WORD = WORD_WIDTH/DATA_WIDTH.
- HSI_BANDS, 128: bands per vector; ELEMENTS = HSI_BANDS/DATA_PER_WORD (64 by default).
- HSI_LIBRARY_SIZE, 32: maximum library vectors; LIB_ADDR = $clog2(HSI_LIBRARY_SIZE).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle command pulse, honoured only in IDLE.
- library_size  in  LIB_ADDR+1  vectors to compare (0..HSI_LIBRARY_SIZE), sampled with start.
- pixel_addr  out  $clog2(ELEMENTS)  pixel buffer read address.
- pixel_data  in  WORD_WIDTH  pixel word, valid 1 cycle after address.
- lib_addr  out  LIB_ADDR+$clog2(ELEMENTS)  library read address = ref*ELEMENTS + j.
- lib_data  in  WORD_WIDTH  library word, valid 1 cycle after address.
- mem_rd_en  out  1  read enable for both memories.
- element_start  out  1  first element of a vector.
- element_last  out  1  last element of a vector.
- element_a  out  WORD_WIDTH  pixel word to hsid_mse.
- element_b  out  WORD_WIDTH  library word to hsid_mse.
- element_valid  out  1  element pair valid.
- vctr_ref  out  LIB_ADDR  library index of the current pair.
- mse_value  in  WORD_WIDTH  result from hsid_mse.
- mse_ref  in  LIB_ADDR  result reference from hsid_mse.
- mse_valid  in  1  result strobe.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- min_mse_value  out  WORD_WIDTH  lowest MSE of the last run.
- min_mse_ref  out  LIB_ADDR  reference index of min_mse_value.
- ref_error  out  1  sticky: a result arrived out of order.

Behaviour:
- Reset (async, any state):
  - state = IDLE.
  - All outputs 0, except min_mse_value = all ones.
  - Internal counters cleared.
  - An operation in progress is abandoned; no done pulse.
- States: IDLE, STREAM, DRAIN, DONE.
- IDLE, start=1:
  - latch library_size into N;
  - clear result count;
  - set min_mse_value = all ones, min_mse_ref = 0, ref_error = 0;
  - go to STREAM (N>0) or DONE (N=0);
  - busy = 1 from the next cycle through the DONE cycle inclusive.
- STREAM issues one read per cycle (mem_rd_en=1):
  - element counter j runs 0..ELEMENTS-1, ref counter r runs 0..N-1;
  - j wraps to 0 and r increments with no bubble;
  - after issuing r=N-1, j=ELEMENTS-1, go to DRAIN.
- Output pipe stage, registered 1 cycle behind the issued address and aligned with the returning memory data:
  - element_valid = 1;
  - element_a = pixel_data, element_b = lib_data;
  - element_start = (j==0), element_last = (j==ELEMENTS-1), vctr_ref = r.
  - First element_valid appears 2 cycles after the start edge.
  - Exactly N*ELEMENTS consecutive valid cycles.
- Result collection, in STREAM and DRAIN, on each mse_valid:
  - if mse_ref != result count, set ref_error;
  - if mse_value < min_mse_value (strict), update min_mse_value and min_mse_ref = mse_ref;
  - equal values keep the earlier (lower) reference;
  - increment result count.
- DRAIN: wait until result count == N, then go to DONE. No timeout.
- DONE:
  - done = 1 for one cycle, then IDLE.
  - min outputs and ref_error hold until the next start or reset.
- start while busy: ignored.
- mse_valid in IDLE: ignored.
- Values of library_size above HSI_LIBRARY_SIZE saturate to HSI_LIBRARY_SIZE.
- vctr_ref and element counters are pure binary; no arithmetic overflow is possible, since lib_addr max = HSI_LIBRARY_SIZE*ELEMENTS-1.

Test Plan:
- Basic run: N=3, memories preloaded; bench MSE model returns mse_value {40,10,25} with mse_ref {0,1,2} → 192 contiguous element_valid cycles; element_start at cycles 0, 64, 128 of the stream; element_last at 63, 127, 191; done once; min_mse_value=10, min_mse_ref=1, ref_error=0.
- Tie handling: N=2, results {7,7} → min_mse_ref=0.
- N=0: start → done one cycle after the start edge; element_valid never asserted; min_mse_value=0xFFFFFFFF, min_mse_ref=0.
- Ordering error: N=2, results arrive with mse_ref {1,0} → ref_error=1 at done; min still correct per values.
- Start while busy: second start pulse mid-STREAM → ignored, stream length unchanged, single done.
- Reset mid-STREAM: rst_n low at stream cycle 30 → all outputs reset immediately. A new start with N=1 then yields a full 64-element stream and a correct result.
